decode_stage: RTL and testbench

Instruction-decode stage of the five-stage RV32I pipeline. Splits the fetched instruction into source and destination register fields and drives the read addresses of the register file. Generates control signals and the sign-extended immediate. Captures everything, together with the register-file read data, in the ID/EX pipeline register consumed by the execute stage. Stall and flush inputs come from the hazard unit. A valid bit marks bubbles.

---
 rtl/riscv_pkg.sv | 81 ++++++++
 rtl/decode_stage_imm_gen.sv | 25 ++
 rtl/decode_stage.sv | 169 ++++++++++++++++
 tb/tb_decode_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, function fields and the control
// encodings carried from decode into execute.
package riscv_pkg;

  localparam int XLEN_P = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    alu_ctrl_t   alu_ctrl;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [XLEN_P-1:0] rd1;
    logic [XLEN_P-1:0] rd2;
    logic [XLEN_P-1:0] imm_ext;
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] pc_plus4;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
  } idex_t;

  // Immediate format depends on the opcode alone, so data fields stay
  // well-defined even for bubbles and illegal encodings.
  function automatic imm_src_t imm_src_for(logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles and sign-extends the I/S/B/J immediates
// from the upper instruction bits.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr_i,
  input  logic [1:0]  imm_src_i,
  output logic [31:0] imm_ext_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm_ext_o = '0;
    case (imm_src_i)
      IMM_I: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_ext_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J: imm_ext_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      default: imm_ext_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register-file addressing, control decode,
// immediate generation and the ID/EX pipeline register with stall/flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_P
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  ctrl_t       ctrl_dec;
  idex_t       idex_cap;
  idex_t       idex_d;
  idex_t       idex_q;

  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  assign A1   = InstrD[19:15];
  assign A2   = InstrD[24:20];
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  imm_gen u_imm_gen (
    .instr_i   (InstrD[31:7]),
    .imm_src_i (imm_src_for(opcode)),
    .imm_ext_o (imm_ext)
  );

  always_comb begin
    ctrl_dec = '0;
    case (opcode)
      OP_LOAD: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.result_src = RES_MEM;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.illegal    = (funct3 != F3_LW);
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.illegal   = (funct3 != F3_SW);
      end
      OP_REG: begin
        ctrl_dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: ctrl_dec.alu_ctrl = ALU_ADD;
          {F7_ALT,  F3_ADD}: ctrl_dec.alu_ctrl = ALU_SUB;
          {F7_BASE, F3_AND}: ctrl_dec.alu_ctrl = ALU_AND;
          {F7_BASE, F3_OR}:  ctrl_dec.alu_ctrl = ALU_OR;
          {F7_BASE, F3_SLT}: ctrl_dec.alu_ctrl = ALU_SLT;
          default:           ctrl_dec.illegal  = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        case (funct3)
          F3_ADD:  ctrl_dec.alu_ctrl = ALU_ADD;
          F3_AND:  ctrl_dec.alu_ctrl = ALU_AND;
          F3_OR:   ctrl_dec.alu_ctrl = ALU_OR;
          F3_SLT:  ctrl_dec.alu_ctrl = ALU_SLT;
          default: ctrl_dec.illegal  = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ctrl_dec.branch   = 1'b1;
        ctrl_dec.alu_ctrl = ALU_SUB;
        ctrl_dec.illegal  = (funct3 != F3_BEQ);
      end
      OP_JAL: begin
        ctrl_dec.jump       = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.result_src = RES_PC4;
      end
      default: ctrl_dec.illegal = 1'b1;
    endcase

    // An illegal encoding must never write state, so only the flag survives.
    if (ctrl_dec.illegal) begin
      ctrl_dec         = '0;
      ctrl_dec.illegal = 1'b1;
    end
    if (rd == 5'd0) ctrl_dec.reg_write = 1'b0;
    if (!ValidD) ctrl_dec = '0;
  end

  always_comb begin
    idex_cap.valid    = ValidD;
    idex_cap.ctrl     = ctrl_dec;
    idex_cap.rd1      = RD1D;
    idex_cap.rd2      = RD2D;
    idex_cap.imm_ext  = imm_ext;
    idex_cap.pc       = PCD;
    idex_cap.pc_plus4 = PCPlus4D;
    idex_cap.rs1      = InstrD[19:15];
    idex_cap.rs2      = InstrD[24:20];
    idex_cap.rd       = rd;
  end

  // Flush outranks stall so a squashed instruction cannot linger in EX.
  always_comb begin
    idex_d = idex_q;
    if (FlushE)       idex_d = '0;
    else if (!StallE) idex_d = idex_cap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign ValidE      = idex_q.valid;
  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign JumpE       = idex_q.ctrl.jump;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign IllegalE    = idex_q.ctrl.illegal;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign ALUControlE = idex_q.ctrl.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases pin the
// reference model, then randomized traffic is compared against it each cycle.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
  logic        ValidD, StallE, FlushE;
  logic [4:0]  A1, A2, Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .StallE(StallE), .FlushE(FlushE),
    .A1(A1), .A2(A2), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  typedef struct {
    bit        valid, rw, mw, jump, branch, alusrc, illegal;
    bit [1:0]  rsrc;
    bit [2:0]  aluc;
    bit [31:0] rd1, rd2, imm, pc, pc4;
    bit [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        model_q;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          cmp_en   = 1'b0;
  bit [31:0]   pc_ctr   = 32'h0000_1000;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: what the ID/EX register must hold after capturing i.
  function automatic exp_t model_decode(bit [31:0] i, bit [31:0] pc, bit [31:0] pc4,
                                        bit [31:0] r1, bit [31:0] r2, bit v);
    exp_t e;
    bit   legal;
    int   imm;
    bit [2:0] f3;
    bit [6:0] f7;
    e  = '{default: 0};
    f3 = i[14:12];
    f7 = i[31:25];
    e.rd1 = r1; e.rd2 = r2; e.pc = pc; e.pc4 = pc4;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    case (i[6:0])
      7'h23:   imm = $signed({i[31:25], i[11:7]});
      7'h63:   imm = $signed({i[31], i[7], i[30:25], i[11:8]}) * 2;
      7'h6f:   imm = $signed({i[31], i[19:12], i[20], i[30:21]}) * 2;
      default: imm = $signed(i[31:20]);
    endcase
    e.imm = imm;
    legal = 1'b0;
    case (i[6:0])
      7'h03: begin legal = (f3 == 3'd2); e.rw = 1; e.rsrc = 2'd1; e.alusrc = 1; end
      7'h23: begin legal = (f3 == 3'd2); e.mw = 1; e.alusrc = 1; end
      7'h33: begin
        e.rw = 1;
        if (f7 == 7'h00) begin
          legal = 1'b1;
          if (f3 == 3'd0)      e.aluc = 3'd0;
          else if (f3 == 3'd7) e.aluc = 3'd2;
          else if (f3 == 3'd6) e.aluc = 3'd3;
          else if (f3 == 3'd2) e.aluc = 3'd5;
          else                 legal = 1'b0;
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          legal = 1'b1; e.aluc = 3'd1;
        end
      end
      7'h13: begin
        e.rw = 1; e.alusrc = 1; legal = 1'b1;
        if (f3 == 3'd0)      e.aluc = 3'd0;
        else if (f3 == 3'd7) e.aluc = 3'd2;
        else if (f3 == 3'd6) e.aluc = 3'd3;
        else if (f3 == 3'd2) e.aluc = 3'd5;
        else                 legal = 1'b0;
      end
      7'h63: begin legal = (f3 == 3'd0); e.branch = 1; e.aluc = 3'd1; end
      7'h6f: begin legal = 1'b1; e.jump = 1; e.rw = 1; e.rsrc = 2'd2; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.rw = 0; e.mw = 0; e.jump = 0; e.branch = 0; e.alusrc = 0;
      e.rsrc = 0; e.aluc = 0; e.illegal = 1;
    end
    if (e.rd == 5'd0) e.rw = 0;
    if (!v) begin
      e.rw = 0; e.mw = 0; e.jump = 0; e.branch = 0; e.alusrc = 0;
      e.rsrc = 0; e.aluc = 0; e.illegal = 0;
    end
    e.valid = v;
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)         model_q = '{default: 0};
    else if (FlushE)  model_q = '{default: 0};
    else if (!StallE) model_q = model_decode(InstrD, PCD, PCPlus4D, RD1D, RD2D, ValidD);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("A1",          A1,          InstrD[19:15]);
      check("A2",          A2,          InstrD[24:20]);
      check("Rs1D",        Rs1D,        InstrD[19:15]);
      check("Rs2D",        Rs2D,        InstrD[24:20]);
      check("ValidE",      ValidE,      model_q.valid);
      check("RegWriteE",   RegWriteE,   model_q.rw);
      check("MemWriteE",   MemWriteE,   model_q.mw);
      check("JumpE",       JumpE,       model_q.jump);
      check("BranchE",     BranchE,     model_q.branch);
      check("ALUSrcE",     ALUSrcE,     model_q.alusrc);
      check("IllegalE",    IllegalE,    model_q.illegal);
      check("ResultSrcE",  ResultSrcE,  model_q.rsrc);
      check("ALUControlE", ALUControlE, model_q.aluc);
      check("RD1E",        RD1E,        model_q.rd1);
      check("RD2E",        RD2E,        model_q.rd2);
      check("ImmExtE",     ImmExtE,     model_q.imm);
      check("PCE",         PCE,         model_q.pc);
      check("PCPlus4E",    PCPlus4E,    model_q.pc4);
      check("Rs1E",        Rs1E,        model_q.rs1);
      check("Rs2E",        Rs2E,        model_q.rs2);
      check("RdE",         RdE,         model_q.rd);
    end
  end

  // Inputs change 1 ns after a rising edge; on return the edge has captured them.
  task automatic drive(bit [31:0] instr, bit [31:0] r1, bit [31:0] r2,
                       bit v, bit st, bit fl);
    InstrD = instr; PCD = pc_ctr; PCPlus4D = pc_ctr + 32'd4;
    RD1D = r1; RD2D = r2; ValidD = v; StallE = st; FlushE = fl;
    @(posedge clk);
    #1;
    pc_ctr += 32'd4;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] i;
    bit [6:0]  ops [6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
    bit [2:0]  f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    int        k;
    i = $urandom;
    k = $urandom_range(0, 6);
    if (k < 6) begin
      i[6:0] = ops[k];
      if ($urandom_range(0, 3) != 0) i[14:12] = f3s[$urandom_range(0, 3)];
      if (k == 2 && $urandom_range(0, 3) != 0)
        i[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
    end
    if ($urandom_range(0, 7) == 0) i[11:7] = 5'd0;
    return i;
  endfunction

  localparam bit [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
  localparam bit [31:0] I_LW   = 32'hFFC1_2283; // lw   x5,-4(x2)
  localparam bit [31:0] I_SW   = 32'h0061_2423; // sw   x6,8(x2)
  localparam bit [31:0] I_BEQ  = 32'hFE20_8CE3; // beq  x1,x2,-8
  localparam bit [31:0] I_JAL  = 32'h0010_00EF; // jal  x1,+2048
  localparam bit [31:0] I_ILL  = 32'h0000_007F;
  localparam bit [31:0] I_ADDI = 32'h0010_0013; // addi x0,x0,1

  initial begin
    rst = 1'b0;
    InstrD = '0; PCD = '0; PCPlus4D = 32'd4; RD1D = '0; RD2D = '0;
    ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_en = 1'b1;
    check("reset_ValidE",    ValidE,    32'd0);
    check("reset_RegWriteE", RegWriteE, 32'd0);
    check("reset_RD1E",      RD1E,      32'd0);

    drive(I_ADD, 32'd5, 32'd7, 1, 0, 0);
    check("add_RegWriteE", RegWriteE,   32'd1);
    check("add_ALUCtrl",   ALUControlE, 32'd0);
    check("add_RdE",       RdE,         32'd3);
    check("add_RD1E",      RD1E,        32'd5);
    check("add_RD2E",      RD2E,        32'd7);
    check("add_A1",        A1,          32'd1);
    check("add_A2",        A2,          32'd2);

    drive(I_LW, 32'd100, 32'd0, 1, 0, 0);
    check("lw_ImmExtE",    ImmExtE,    32'hFFFF_FFFC);
    check("lw_ResultSrcE", ResultSrcE, 32'd1);
    check("lw_ALUSrcE",    ALUSrcE,    32'd1);

    drive(I_SW, 32'd100, 32'd9, 1, 0, 0);
    check("sw_ImmExtE",    ImmExtE,   32'd8);
    check("sw_MemWriteE",  MemWriteE, 32'd1);
    check("sw_RegWriteE",  RegWriteE, 32'd0);

    drive(I_BEQ, 32'd1, 32'd1, 1, 0, 0);
    check("beq_ImmExtE",   ImmExtE,     32'hFFFF_FFF8);
    check("beq_BranchE",   BranchE,     32'd1);
    check("beq_ALUCtrl",   ALUControlE, 32'd1);

    drive(I_JAL, 32'd0, 32'd0, 1, 0, 0);
    check("jal_ImmExtE",    ImmExtE,    32'h0000_0800);
    check("jal_ResultSrcE", ResultSrcE, 32'd2);
    check("jal_JumpE",      JumpE,      32'd1);

    drive(I_ADD, 32'd5, 32'd7, 1, 0, 0);
    for (int s = 0; s < 2; s++) begin
      drive(I_LW, 32'd55, 32'd66, 1, 1, 0);
      check("stall_RdE",       RdE,       32'd3);
      check("stall_RD1E",      RD1E,      32'd5);
      check("stall_RegWriteE", RegWriteE, 32'd1);
    end

    drive(I_ADD, 32'd5, 32'd7, 1, 1, 1);
    check("flush_ValidE",    ValidE,    32'd0);
    check("flush_RegWriteE", RegWriteE, 32'd0);

    drive(I_ILL, 32'd0, 32'd0, 1, 0, 0);
    check("ill_IllegalE",  IllegalE,  32'd1);
    check("ill_RegWriteE", RegWriteE, 32'd0);
    check("ill_MemWriteE", MemWriteE, 32'd0);
    check("ill_BranchE",   BranchE,   32'd0);
    check("ill_JumpE",     JumpE,     32'd0);
    check("ill_ValidE",    ValidE,    32'd1);

    drive(I_ADDI, 32'd0, 32'd0, 1, 0, 0);
    check("addi_x0_RegWriteE", RegWriteE, 32'd0);
    check("addi_x0_ALUSrcE",   ALUSrcE,   32'd1);

    drive(I_ADD, 32'd5, 32'd7, 0, 0, 0);
    check("bubble_ValidE",    ValidE,    32'd0);
    check("bubble_RegWriteE", RegWriteE, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      drive(rand_instr(), $urandom, $urandom, ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      if (n == 1500) begin
        drive(I_JAL, 32'd3, 32'd4, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ValidE",    ValidE,    32'd0);
        check("async_rst_RegWriteE", RegWriteE, 32'd0);
        check("async_rst_JumpE",     JumpE,     32'd0);
        check("async_rst_ImmExtE",   ImmExtE,   32'd0);
        check("async_rst_PCE",       PCE,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
